// File: rtl/lime_pkg.sv
// Shared definitions for TheLime and its output-side monitor.
package lime_pkg;

  // Width of TheLime's main_output word.
  localparam int LIME_WORD_W = 16;
  // Width of the monitor's free-running cycle counter and timestamps.
  localparam int LIME_CNT_W = 32;
  // Default number of capture entries held by the monitor.
  localparam int LIME_MON_DEPTH = 4;

  // One monitor capture: the output value and the cycle stamp it was seen at.
  typedef struct packed {
    logic [LIME_WORD_W-1:0] data;
    logic [LIME_CNT_W-1:0]  cycles;
  } lime_mon_entry_t;

  // Build an entry from its two fields.
  function automatic lime_mon_entry_t lime_mon_pack(
    input logic [LIME_WORD_W-1:0] data,
    input logic [LIME_CNT_W-1:0]  cycles
  );
    lime_mon_entry_t e;
    e.data   = data;
    e.cycles = cycles;
    return e;
  endfunction

endpackage

// File: rtl/lime_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level/full reporting.
//
// Handshake: wr_en_i is a push request; it is accepted unless the FIFO is
// full and no pop happens at the same edge, in which case the word is
// discarded and drop_o pulses for that cycle. rd_valid_o means the head
// word is on rd_data_o right now; rd_en_i with rd_valid_o pops it at the
// edge, and rd_en_i while empty is ignored. A push into an empty FIFO is
// always kept, even when rd_en_i is high.
module lime_sync_fifo
  import lime_pkg::*;
#(
  parameter int WIDTH = LIME_WORD_W + LIME_CNT_W,
  parameter int DEPTH = LIME_MON_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic                   rd_valid_o,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;

  // Occupancy decode and accepted push/pop for this edge.
  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == LVL_W'(DEPTH));
    do_pop  = rd_en_i & ~empty;
    // A pop frees a slot at the same edge, so full-with-pop still accepts.
    do_push = wr_en_i & (~full | do_pop);
    drop_o  = wr_en_i & full & ~do_pop;
  end

  // Next pointers and level; DEPTH is a power of two so pointers wrap freely.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  // Pointer and level registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because reads are gated by level.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Head presented combinationally, forced to zero when empty.
  always_comb begin
    rd_valid_o = ~empty;
    rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    full_o     = full;
    level_o    = level_q;
  end

endmodule

// File: rtl/lime_output_monitor.sv
// Watches TheLime's main_output and logs every change with its cycle stamp.
module lime_output_monitor
  import lime_pkg::*;
#(
  parameter int DATA_W = LIME_WORD_W,
  parameter int CNT_W  = LIME_CNT_W,
  parameter int DEPTH  = LIME_MON_DEPTH
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [DATA_W-1:0]      proc_output,
  input  logic                   clear_cnt,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [CNT_W-1:0]       rd_cycles,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int ENTRY_W = DATA_W + CNT_W;

  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [DATA_W-1:0]  prev_q;
  logic               overflow_q, overflow_d;

  logic               chg;
  logic               drop;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Change detect and capture word; the stamp is the count before this edge.
  always_comb begin
    chg        = (proc_output != prev_q);
    push_entry = {proc_output, cycle_cnt_q};
  end

  // Next counter and sticky overflow; a drop at the clearing edge wins.
  always_comb begin
    cycle_cnt_d = clear_cnt ? '0 : cycle_cnt_q + CNT_W'(1);
    overflow_d  = overflow_q;
    if (clear_cnt) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Counter, previous-output and overflow registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cycle_cnt_q <= '0;
      prev_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      prev_q      <= proc_output;
      overflow_q  <= overflow_d;
    end
  end

  lime_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (Reset),
    .wr_en_i    (chg),
    .wr_data_i  (push_entry),
    .rd_en_i    (rd_en),
    .rd_valid_o (rd_valid),
    .rd_data_o  (head_entry),
    .full_o     (full),
    .level_o    (level),
    .drop_o     (drop)
  );

  // Split the head entry into its value and stamp fields.
  always_comb begin
    rd_data   = head_entry[ENTRY_W-1:CNT_W];
    rd_cycles = head_entry[CNT_W-1:0];
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_lime_output_monitor.sv
// Directed and randomized checks of lime_output_monitor against a queue model.
module tb_lime_output_monitor;
  import lime_pkg::*;

  localparam int DW    = LIME_WORD_W;
  localparam int CW    = LIME_CNT_W;
  localparam int DEPTH = LIME_MON_DEPTH;
  localparam int EW    = DW + CW;

  // Clock / reset and DUT signals
  logic                   CLK = 1'b0;
  logic                   Reset;
  logic [DW-1:0]          proc_output;
  logic                   clear_cnt;
  logic                   rd_en;
  logic                   rd_valid;
  logic [DW-1:0]          rd_data;
  logic [CW-1:0]          rd_cycles;
  logic                   full;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;

  always #5 CLK = ~CLK;

  lime_output_monitor #(
    .DATA_W (DW),
    .CNT_W  (CW),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .proc_output (proc_output),
    .clear_cnt   (clear_cnt),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_cycles   (rd_cycles),
    .full        (full),
    .level       (level),
    .overflow    (overflow)
  );

  // Reference model: queue of {value, stamp}, counter, last output, sticky flag
  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] m_cnt;
  logic [DW-1:0] m_prev;
  logic          m_ovf;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt  = '0;
    m_prev = '0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of behaviour, using the inputs present at that edge.
  task automatic model_edge();
    bit pop;
    bit push;
    bit dropped;
    if (Reset) begin
      model_reset();
      return;
    end
    pop     = rd_en && (exp_q.size() > 0);
    push    = (proc_output != m_prev);
    dropped = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({proc_output, m_cnt});
      else dropped = 1'b1;
    end
    if (clear_cnt) m_ovf = 1'b0;
    if (dropped)   m_ovf = 1'b1;
    m_cnt  = clear_cnt ? '0 : m_cnt + 1;
    m_prev = proc_output;
  endtask

  task automatic check_all();
    logic [EW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("rd_valid",  rd_valid,  exp_q.size() != 0);
    chk("level",     level,     exp_q.size());
    chk("full",      full,      exp_q.size() == DEPTH);
    chk("overflow",  overflow,  m_ovf);
    chk("rd_data",   rd_data,   head[EW-1:CW]);
    chk("rd_cycles", rd_cycles, head[CW-1:0]);
  endtask

  // Driver: apply inputs, take one edge, update model, check 1 ns later.
  task automatic step(input logic [DW-1:0] p, input bit r, input bit c);
    proc_output = p;
    rd_en       = r;
    clear_cnt   = c;
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  logic [DW-1:0] drain_vals [4];

  initial begin
    drain_vals[0] = 16'h0906;
    drain_vals[1] = 16'h000d;
    drain_vals[2] = 16'h0030;
    drain_vals[3] = 16'h0005;

    // 1. Reset for 3 cycles
    Reset = 1'b1; proc_output = '0; rd_en = 1'b0; clear_cnt = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_all();
    Reset = 1'b0;

    // 2. Single change 0->5 before edge 10 after release
    for (int i = 1; i <= 9; i++) step(16'h0000, 1'b0, 1'b0);
    step(16'h0005, 1'b0, 1'b0);
    chk("t2_data",  rd_data,   16'h0005);
    chk("t2_stamp", rd_cycles, 32'd9);
    chk("t2_level", level,     1);
    step(16'h0005, 1'b0, 1'b0);
    chk("t2_hold_level", level, 1);
    step(16'h0005, 1'b1, 1'b0);
    chk("t2_popped", rd_valid, 1'b0);

    // 3. Four consecutive changes fill the FIFO, fifth is dropped
    for (int k = 0; k < 4; k++) step(drain_vals[k], 1'b0, 1'b0);
    chk("t3_full",  full,  1'b1);
    chk("t3_level", level, 4);
    step(16'h0001, 1'b0, 1'b0);
    chk("t3_ovf",   overflow, 1'b1);
    chk("t3_level_after_drop", level, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain_data",  rd_data,   drain_vals[k]);
      chk("t3_drain_stamp", rd_cycles, 32'(12 + k));
      step(16'h0001, 1'b1, 1'b0);
    end
    chk("t3_empty", rd_valid, 1'b0);

    // 4. Full FIFO, change and pop at the same edge
    step(16'h0001, 1'b0, 1'b1);
    chk("t4_ovf_cleared", overflow, 1'b0);
    step(16'h0002, 1'b0, 1'b0);
    step(16'h0003, 1'b0, 1'b0);
    step(16'h0004, 1'b0, 1'b0);
    step(16'h0005, 1'b0, 1'b0);
    step(16'h0006, 1'b1, 1'b0);
    chk("t4_level", level,    4);
    chk("t4_ovf",   overflow, 1'b0);
    step(16'h0009, 1'b0, 1'b0);
    chk("t4_drop_ovf", overflow, 1'b1);
    for (int k = 0; k < 4; k++) step(16'h0009, 1'b1, 1'b0);
    chk("t4_tail_drained", level, 0);

    // 5. clear_cnt at the same edge as a change to 0x0007
    step(16'h0007, 1'b0, 1'b1);
    chk("t5_ovf_cleared", overflow, 1'b0);
    step(16'h0007, 1'b0, 1'b0);
    step(16'h0011, 1'b1, 1'b0);
    chk("t5_post_clear_stamp", rd_cycles, 32'd1);

    // 6. Asynchronous reset mid-drain with level=2
    step(16'h0012, 1'b0, 1'b0);
    step(16'h0013, 1'b0, 1'b0);
    step(16'h0014, 1'b0, 1'b0);
    step(16'h0015, 1'b0, 1'b0);
    step(16'h0015, 1'b1, 1'b0);
    step(16'h0015, 1'b1, 1'b0);
    chk("t6_pre_level", level,    2);
    chk("t6_pre_ovf",   overflow, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    chk("t6_async_valid", rd_valid, 1'b0);
    chk("t6_async_level", level,    0);
    chk("t6_async_ovf",   overflow, 1'b0);
    check_all();
    step(16'h0015, 1'b1, 1'b0);
    Reset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] p;
      bit r;
      bit c;
      p = ($urandom_range(0, 9) == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
      r = ($urandom_range(0, 99) < (((i / 100) % 2 == 0) ? 20 : 75));
      c = ($urandom_range(0, 49) == 0);
      step(p, r, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
